pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised pipeline-stage register; successor to the fixed 32-bit clear-only DFF.
//  Carries WIDTH-bit payload between CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB)
//  with valid/ready handshake, stall back-pressure and flush (bubble insertion).
//  SKID=1 adds a 2-entry skid buffer so in_ready is registered (cuts ready timing path).
// PARAMETERS
//  WIDTH      32  payload width in bits
//  RESET_VAL  0   value driven on out_data after reset (WIDTH bits)
//  SKID       1   1: 2-entry skid buffer, registered in_ready; 0: single register, comb in_ready
// PORTS
//  clk        in   1      rising-edge clock
//  clr        in   1      reset: one clock; reset is synchronous and active-high
//  flush      in   1      drop all held entries this edge (branch/exception squash)
//  in_valid   in   1      upstream offers in_data
//  in_ready   out  1      stage accepts in_data this edge
//  in_data    in   WIDTH  payload from upstream stage
//  out_valid  out  1      out_data holds a live entry
//  out_ready  in   1      downstream consumes out_data this edge
//  out_data   out  WIDTH  payload to downstream stage
//  occ        out  2      entries held (0..2; max 1 when SKID=0)
// BEHAVIOUR
//  - Reset (clr=1 at edge): out_valid=0, out_data=RESET_VAL, occ=0, in_ready=1 after edge.
//    clr overrides flush, in_valid, out_ready. Mid-transfer reset discards all entries.
//  - accept = in_valid & in_ready; consume = out_valid & out_ready (both sampled at edge).
//  - Latency: accepted word appears on out_data/out_valid the cycle after acceptance.
//  - Order preserved; no word duplicated or dropped except by flush/clr.
//  SKID=1 state machine (occ encodes state):
//    EMPTY(0): accept -> ONE (main<=in_data).
//    ONE(1):   accept&consume -> ONE (main<=in_data); accept&!consume -> FULL (skid<=in_data);
//              !accept&consume -> EMPTY; else hold.
//    FULL(2):  in_ready=0; consume -> ONE (main<=skid); else hold.
//    in_ready = (occ!=2), driven from a flop, never from out_ready.
//  SKID=0: single register; in_ready = !out_valid | out_ready (combinational).
//    accept&consume same edge -> stays occupied with new word.
//  - flush=1 at edge (clr=0): all entries invalidated, occ=0, out_valid=0, in_ready=1 next;
//    flush wins over a simultaneous accept (incoming word dropped) and consume.
//    Data flops NOT cleared by flush; out_data holds last value while out_valid=0.
//  - out_data only changes when a new word is loaded into main; stable while out_valid&!out_ready.
//  - in_data ignored when !in_valid; X on in_data with in_valid=0 must not propagate.
// STRUCTURE
//  - Shared package pipe_pkg: occ encoding localparams OCC_EMPTY=2'd0, OCC_ONE=2'd1,
//    OCC_FULL=2'd2; default WIDTH used by stage instantiations.
//  - Sub-module dff_en_w (WIDTH, RESET_VAL): enabled register with sync active-high clr;
//    instantiated twice (main, skid); skid instance generated only when SKID=1.
//  - Control (occ, valids, in_ready flop) inline in pipe_stage_reg.
// TESTING
//  1 Reset: clr=1 two cycles with in_valid=1 -> out_valid=0, out_data=RESET_VAL, occ=0,
//    in_ready=1 first cycle after clr falls.
//  2 Streaming: out_ready=1, push 0x1,0x2,0x3 back-to-back -> out_data 0x1,0x2,0x3 on the
//    following 3 cycles, occ=1 throughout, in_ready never drops.
//  3 Stall (SKID=1): out_ready=0, push 0xA,0xB -> occ=2, in_ready=0, 0xC held off; release
//    out_ready -> 0xA then 0xB then 0xC delivered in order, no loss.
//  4 Flush with accept: occ=2, flush=1 and in_valid=1 (0xD) same edge -> occ=0,
//    out_valid=0, 0xD not delivered; next push 0xE appears one cycle later.
//  5 SKID=0 build: out_ready=0 with word held -> in_ready=0 same cycle; out_ready=1 and
//    in_valid=1 same edge -> replacement word appears next cycle, occ stays 1.
//  6 Random valid/ready/flush, 10k cycles, WIDTH=8 and 64 -> scoreboard order match, occ<=2.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline-stage registers: occupancy encoding and default payload width.
package pipe_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    // State values equal the occupancy count so occ can be driven straight from the state flop.
    typedef enum logic [1:0] {
        ST_EMPTY = OCC_EMPTY,
        ST_ONE   = OCC_ONE,
        ST_FULL  = OCC_FULL
    } occ_state_e;

    function automatic logic occ_has_room(input logic [1:0] occ_val);
        return occ_val != OCC_FULL;
    endfunction

endpackage

// File: rtl/dff_en_w.sv
// WIDTH-bit register with load enable and synchronous active-high clear to RESET_VAL.
module dff_en_w #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (clr_i) begin
            data_q <= RESET_VAL;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, flush, and optional 2-entry skid buffer
// (SKID=1) that makes in_ready a flop output independent of out_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               SKID      = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occ
);

    occ_state_e       state_q, state_d;
    logic             in_ready_q;
    logic             accept, consume;
    logic             main_en, skid_en;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;

    assign out_valid = (state_q != ST_EMPTY);
    assign occ       = state_q;
    assign in_ready  = SKID ? in_ready_q : (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= occ_has_room(state_d);
        end
    end

    // Data enables are only raised on accept/skid drain, so in_data is never sampled when idle.
    always_comb begin
        state_d = state_q;
        main_en = 1'b0;
        skid_en = 1'b0;
        main_d  = in_data;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    main_en = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && consume) begin
                    main_en = 1'b1;
                end else if (accept) begin
                    if (SKID) begin
                        state_d = ST_FULL;
                        skid_en = 1'b1;
                    end else begin
                        main_en = 1'b1;
                    end
                end else if (consume) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (consume) begin
                    state_d = ST_ONE;
                    main_en = 1'b1;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        // Flush invalidates everything but leaves the data flops untouched.
        if (flush) begin
            state_d = ST_EMPTY;
            main_en = 1'b0;
            skid_en = 1'b0;
        end
    end

    dff_en_w #(
        .WIDTH    (WIDTH),
        .RESET_VAL(RESET_VAL)
    ) u_main (
        .clk  (clk),
        .clr_i(clr),
        .en_i (main_en),
        .d_i  (main_d),
        .q_o  (out_data)
    );

    if (SKID) begin : g_skid
        dff_en_w #(
            .WIDTH    (WIDTH),
            .RESET_VAL('0)
        ) u_skid (
            .clk  (clk),
            .clr_i(clr),
            .en_i (skid_en),
            .d_i  (in_data),
            .q_o  (skid_q)
        );
    end else begin : g_no_skid
        logic unused_skid_en;
        assign unused_skid_en = skid_en;
        assign skid_q         = '0;
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench: directed scenarios plus a randomised scoreboard run on an 8-bit skid
// stage and a 64-bit single-register stage.
module tb_pipe_stage_reg;

    localparam logic [7:0]  RST_A = 8'hA5;
    localparam logic [63:0] RST_B = 64'h0123_4567_89AB_CDEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    logic        a_clr, a_flush, a_iv, a_ir, a_ov, a_or;
    logic [7:0]  a_id, a_od, a_exp;
    logic [1:0]  a_occ;
    logic        b_clr, b_flush, b_iv, b_ir, b_ov, b_or;
    logic [63:0] b_id, b_od, b_exp;
    logic [1:0]  b_occ;

    logic [7:0]  sb_a[$];
    logic [63:0] sb_b[$];

    pipe_stage_reg #(.WIDTH(8), .RESET_VAL(RST_A), .SKID(1'b1)) u_a (
        .clk(clk), .clr(a_clr), .flush(a_flush), .in_valid(a_iv), .in_ready(a_ir),
        .in_data(a_id), .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .occ(a_occ)
    );

    pipe_stage_reg #(.WIDTH(64), .RESET_VAL(RST_B), .SKID(1'b0)) u_b (
        .clk(clk), .clr(b_clr), .flush(b_flush), .in_valid(b_iv), .in_ready(b_ir),
        .in_data(b_id), .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .occ(b_occ)
    );

    // Scoreboard for stage A: inputs are stable from posedge+1 to the next posedge,
    // so the negedge sees exactly what the coming edge will act on.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++; if (a_occ !== 2'(sb_a.size())) begin failures++; $display("FAIL sb_a_occ got=%0d exp=%0d", a_occ, sb_a.size()); end
            checks++; if (a_ov !== (sb_a.size() != 0)) begin failures++; $display("FAIL sb_a_valid got=%0b exp=%0b", a_ov, sb_a.size() != 0); end
            checks++; if (a_ir !== (sb_a.size() < 2)) begin failures++; $display("FAIL sb_a_ready got=%0b exp=%0b", a_ir, sb_a.size() < 2); end
            if (a_clr || a_flush) begin
                sb_a.delete();
            end else begin
                if (a_ov && a_or) begin
                    checks++;
                    if (sb_a.size() == 0) begin
                        failures++; $display("FAIL sb_a_data got=%h exp=none", a_od);
                    end else begin
                        a_exp = sb_a.pop_front();
                        if (a_od !== a_exp) begin failures++; $display("FAIL sb_a_data got=%h exp=%h", a_od, a_exp); end
                    end
                end else if (a_ov && sb_a.size() != 0) begin
                    checks++; if (a_od !== sb_a[0]) begin failures++; $display("FAIL sb_a_hold got=%h exp=%h", a_od, sb_a[0]); end
                end
                if (a_iv && a_ir) sb_a.push_back(a_id);
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            checks++; if (b_occ !== 2'(sb_b.size())) begin failures++; $display("FAIL sb_b_occ got=%0d exp=%0d", b_occ, sb_b.size()); end
            checks++; if (b_ov !== (sb_b.size() != 0)) begin failures++; $display("FAIL sb_b_valid got=%0b exp=%0b", b_ov, sb_b.size() != 0); end
            checks++; if (b_ir !== (sb_b.size() == 0 || b_or)) begin failures++; $display("FAIL sb_b_ready got=%0b exp=%0b", b_ir, sb_b.size() == 0 || b_or); end
            if (b_clr || b_flush) begin
                sb_b.delete();
            end else begin
                if (b_ov && b_or) begin
                    checks++;
                    if (sb_b.size() == 0) begin
                        failures++; $display("FAIL sb_b_data got=%h exp=none", b_od);
                    end else begin
                        b_exp = sb_b.pop_front();
                        if (b_od !== b_exp) begin failures++; $display("FAIL sb_b_data got=%h exp=%h", b_od, b_exp); end
                    end
                end else if (b_ov && sb_b.size() != 0) begin
                    checks++; if (b_od !== sb_b[0]) begin failures++; $display("FAIL sb_b_hold got=%h exp=%h", b_od, sb_b[0]); end
                end
                if (b_iv && b_ir) sb_b.push_back(b_id);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_clr = 1'b1; a_flush = 1'b0; a_iv = 1'b1; a_or = 1'b1; a_id = 8'h55;
        b_clr = 1'b1; b_flush = 1'b0; b_iv = 1'b1; b_or = 1'b1; b_id = 64'h55;
        repeat (2) step();
        a_clr = 1'b0; a_iv = 1'b0; a_or = 1'b0;
        b_clr = 1'b0; b_iv = 1'b0; b_or = 1'b0;
        #1;
        checks++; if (a_ov !== 1'b0) begin failures++; $display("FAIL reset_a_valid got=%0b exp=0", a_ov); end
        checks++; if (a_od !== RST_A) begin failures++; $display("FAIL reset_a_data got=%h exp=%h", a_od, RST_A); end
        checks++; if (a_occ !== 2'd0) begin failures++; $display("FAIL reset_a_occ got=%0d exp=0", a_occ); end
        checks++; if (a_ir !== 1'b1) begin failures++; $display("FAIL reset_a_ready got=%0b exp=1", a_ir); end
        checks++; if (b_ov !== 1'b0) begin failures++; $display("FAIL reset_b_valid got=%0b exp=0", b_ov); end
        checks++; if (b_od !== RST_B) begin failures++; $display("FAIL reset_b_data got=%h exp=%h", b_od, RST_B); end
        checks++; if (b_occ !== 2'd0) begin failures++; $display("FAIL reset_b_occ got=%0d exp=0", b_occ); end
        checks++; if (b_ir !== 1'b1) begin failures++; $display("FAIL reset_b_ready got=%0b exp=1", b_ir); end
        mon_en = 1'b1;
    endtask

    task automatic test_streaming();
        a_or = 1'b1; a_iv = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            a_id = 8'(k);
            step();
            checks++; if (a_od !== 8'(k)) begin failures++; $display("FAIL stream_data got=%h exp=%h", a_od, 8'(k)); end
            checks++; if (a_occ !== 2'd1) begin failures++; $display("FAIL stream_occ got=%0d exp=1", a_occ); end
            checks++; if (a_ir !== 1'b1) begin failures++; $display("FAIL stream_ready got=%0b exp=1", a_ir); end
        end
        a_iv = 1'b0;
        step();
        checks++; if (a_occ !== 2'd0) begin failures++; $display("FAIL stream_drain_occ got=%0d exp=0", a_occ); end
    endtask

    task automatic test_stall();
        a_or = 1'b0; a_iv = 1'b1; a_id = 8'h0A;
        step();
        checks++; if (a_occ !== 2'd1 || a_od !== 8'h0A) begin failures++; $display("FAIL stall_first got occ=%0d data=%h exp occ=1 data=0a", a_occ, a_od); end
        a_id = 8'h0B;
        step();
        checks++; if (a_occ !== 2'd2) begin failures++; $display("FAIL stall_full_occ got=%0d exp=2", a_occ); end
        checks++; if (a_ir !== 1'b0) begin failures++; $display("FAIL stall_full_ready got=%0b exp=0", a_ir); end
        a_id = 8'h0C;
        step();
        checks++; if (a_occ !== 2'd2 || a_od !== 8'h0A) begin failures++; $display("FAIL stall_hold got occ=%0d data=%h exp occ=2 data=0a", a_occ, a_od); end
        a_or = 1'b1;
        step();
        checks++; if (a_od !== 8'h0B || a_occ !== 2'd1) begin failures++; $display("FAIL stall_rel_b got data=%h occ=%0d exp data=0b occ=1", a_od, a_occ); end
        checks++; if (a_ir !== 1'b1) begin failures++; $display("FAIL stall_rel_ready got=%0b exp=1", a_ir); end
        step();
        checks++; if (a_od !== 8'h0C || a_occ !== 2'd1) begin failures++; $display("FAIL stall_rel_c got data=%h occ=%0d exp data=0c occ=1", a_od, a_occ); end
        a_iv = 1'b0;
        step();
        checks++; if (a_ov !== 1'b0) begin failures++; $display("FAIL stall_drain got=%0b exp=0", a_ov); end
    endtask

    task automatic test_flush();
        a_or = 1'b0; a_iv = 1'b1; a_id = 8'h01;
        step();
        a_id = 8'h02;
        step();
        checks++; if (a_occ !== 2'd2) begin failures++; $display("FAIL flush_pre_occ got=%0d exp=2", a_occ); end
        a_flush = 1'b1; a_id = 8'h0D;
        step();
        a_flush = 1'b0; a_iv = 1'b0;
        checks++; if (a_occ !== 2'd0 || a_ov !== 1'b0) begin failures++; $display("FAIL flush_state got occ=%0d valid=%0b exp occ=0 valid=0", a_occ, a_ov); end
        checks++; if (a_ir !== 1'b1) begin failures++; $display("FAIL flush_ready got=%0b exp=1", a_ir); end
        checks++; if (a_od !== 8'h01) begin failures++; $display("FAIL flush_keep_data got=%h exp=01", a_od); end
        a_iv = 1'b1; a_id = 8'h0E; a_or = 1'b1;
        step();
        checks++; if (a_ov !== 1'b1 || a_od !== 8'h0E) begin failures++; $display("FAIL flush_next got valid=%0b data=%h exp valid=1 data=0e", a_ov, a_od); end
        a_or = 1'b0; a_id = 8'h0F; a_flush = 1'b1;
        step();
        a_flush = 1'b0; a_iv = 1'b0;
        checks++; if (a_occ !== 2'd0 || a_od !== 8'h0E) begin failures++; $display("FAIL flush_one got occ=%0d data=%h exp occ=0 data=0e", a_occ, a_od); end
        step();
        checks++; if (a_ov !== 1'b0) begin failures++; $display("FAIL flush_dropped got=%0b exp=0", a_ov); end
    endtask

    task automatic test_skid0();
        b_or = 1'b1; b_iv = 1'b1; b_id = 64'h1111_0000_0000_0011;
        step();
        checks++; if (b_ov !== 1'b1 || b_od !== 64'h1111_0000_0000_0011) begin failures++; $display("FAIL s0_load got valid=%0b data=%h", b_ov, b_od); end
        b_or = 1'b0; b_id = 64'h2222_0000_0000_0022;
        #1;
        checks++; if (b_ir !== 1'b0) begin failures++; $display("FAIL s0_ready_comb got=%0b exp=0", b_ir); end
        step();
        checks++; if (b_od !== 64'h1111_0000_0000_0011) begin failures++; $display("FAIL s0_stall got=%h exp=1111000000000011", b_od); end
        b_or = 1'b1;
        #1;
        checks++; if (b_ir !== 1'b1) begin failures++; $display("FAIL s0_ready_rel got=%0b exp=1", b_ir); end
        step();
        checks++; if (b_od !== 64'h2222_0000_0000_0022 || b_occ !== 2'd1) begin failures++; $display("FAIL s0_replace got data=%h occ=%0d", b_od, b_occ); end
        b_id = 64'h3333_0000_0000_0033;
        step();
        checks++; if (b_od !== 64'h3333_0000_0000_0033 || b_occ !== 2'd1) begin failures++; $display("FAIL s0_b2b got data=%h occ=%0d", b_od, b_occ); end
        b_iv = 1'b0;
        step();
        checks++; if (b_ov !== 1'b0 || b_occ !== 2'd0) begin failures++; $display("FAIL s0_drain got valid=%0b occ=%0d", b_ov, b_occ); end
        b_or = 1'b0;
        #1;
        checks++; if (b_ir !== 1'b1) begin failures++; $display("FAIL s0_empty_ready got=%0b exp=1", b_ir); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 10000; n++) begin
            a_clr   = ($urandom_range(0, 999) == 0);
            a_flush = ($urandom_range(0, 39) == 0);
            a_iv    = ($urandom_range(0, 3) != 0);
            a_or    = ($urandom_range(0, 2) != 0);
            a_id    = 8'($urandom);
            b_clr   = ($urandom_range(0, 999) == 0);
            b_flush = ($urandom_range(0, 39) == 0);
            b_iv    = ($urandom_range(0, 3) != 0);
            b_or    = ($urandom_range(0, 2) != 0);
            b_id    = {$urandom, $urandom};
            step();
            checks++; if (a_occ > 2'd2 || b_occ > 2'd1) begin failures++; $display("FAIL rand_occ_range got a=%0d b=%0d", a_occ, b_occ); end
        end
        a_clr = 1'b0; a_flush = 1'b0; a_iv = 1'b0; a_or = 1'b1;
        b_clr = 1'b0; b_flush = 1'b0; b_iv = 1'b0; b_or = 1'b1;
        repeat (4) step();
        checks++; if (sb_a.size() != 0 || a_occ !== 2'd0) begin failures++; $display("FAIL rand_a_drain got occ=%0d left=%0d exp 0", a_occ, sb_a.size()); end
        checks++; if (sb_b.size() != 0 || b_occ !== 2'd0) begin failures++; $display("FAIL rand_b_drain got occ=%0d left=%0d exp 0", b_occ, sb_b.size()); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_stall();
        test_flush();
        test_skid0();
        test_random();
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
